ras_ckpt: RTL and testbench
===========================

Name: ras_ckpt

Overview:
Parametrised return address stack for the fetch predictors, the successor to the fixed 8-entry RAS. It adds configurable depth and target width, saturating occupancy tracking, and checkpoint restore for branch mispredict recovery. It also handles push and pop in the same cycle as a top-of-stack replace, for jalr call-return (coroutine) sequences. It sits beside the BTB and GBPT in the fetch stage; the checkpoint array and ROB hold {index, count} tags and drive the restore port on a flush.

Parameters:
RAS_ENTRIES, 8, stack depth; power of 2, minimum 2.
RAS_INDEX_WIDTH, $clog2(RAS_ENTRIES), pointer width.
RAS_TARGET_WIDTH, 31, stored target width (PC[31:1]).

Ports:
CLK  in  1  clock.
RST  in  1  reset; synchronous, active-high.
push_valid  in  1  push request (call).
push_target  in  RAS_TARGET_WIDTH  return address to push.
pop_valid  in  1  pop request (return).
pop_target  out  RAS_TARGET_WIDTH  current top-of-stack entry; combinational from array[ptr].
ras_index  out  RAS_INDEX_WIDTH  current top pointer; checkpoint tag field.
ras_count  out  RAS_INDEX_WIDTH+1  valid entry count, range 0..RAS_ENTRIES; checkpoint tag field.
ras_empty  out  1  ras_count == 0.
ras_underflow  out  1  registered; high for 1 cycle after a pop while empty.
restore_valid  in  1  restore stack state from a checkpoint.
restore_index  in  RAS_INDEX_WIDTH  checkpointed ptr.
restore_count  in  RAS_INDEX_WIDTH+1  checkpointed count; values above RAS_ENTRIES clamp to RAS_ENTRIES.

Behaviour:
- Storage: circular array of RAS_ENTRIES targets; ptr points at the top entry; all pointer arithmetic is mod RAS_ENTRIES.
- Reset (synchronous on RST): ptr=0, count=0, all entries=0, ras_underflow=0. Resulting outputs: pop_target=0, ras_index=0, ras_count=0, ras_empty=1.
- Update priority per cycle: RST > restore_valid > push/pop. Push and pop are ignored in a restore cycle.
- Restore:
  - ptr <= restore_index; count <= min(restore_count, RAS_ENTRIES).
  - Array contents are untouched; entries overwritten after the checkpoint stay corrupted, which is accepted.
- Push only:
  - ptr <= ptr+1; array[ptr+1] <= push_target.
  - count <= min(count+1, RAS_ENTRIES).
  - When full, the oldest entry is silently overwritten (wrap-around).
- Pop only, count>0: ptr <= ptr-1; count <= count-1. pop_target shows the pre-pop top in that cycle.
- Pop only, count==0:
  - ptr and count unchanged; pop_target shows the stale array[ptr].
  - ras_underflow <= 1 for the next cycle.
- Push and pop together (replace):
  - array[ptr] <= push_target; ptr unchanged.
  - count <= max(count,1).
  - pop_target in that cycle shows the old top. No underflow is flagged.
- No read-after-write bypass: a push in cycle N is visible on pop_target in cycle N+1.
- Latency: all state updates take effect on the next CLK edge; pop_target, ras_index, ras_count and ras_empty are combinational from the registered state.
- ras_underflow is 0 in every cycle not immediately following an empty-pop.

Optional Feature:
- Macro RAS_CKPT_STATS_EN.
- When defined, add two outputs:
  - stat_overflow_count (16 bits): increments on each push made while count==RAS_ENTRIES.
  - stat_underflow_count (16 bits): increments on each pop-only made while count==0.
- Both counters saturate at 16'hFFFF, clear on RST, and are not affected by restore.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
1. Reset, then push 31'h100, 31'h200, 31'h300 on consecutive cycles -> ras_count=3, ras_index=3, pop_target=31'h300. Then three pops return 31'h300, 31'h200, 31'h100 in order; ras_empty=1 afterwards.
2. RAS_ENTRIES=8: push 31'h1..31'h9 (9 pushes) -> ras_count saturates at 8 and ras_index=1 (wrapped). Eight pops return 31'h9 down to 31'h2. A 9th pop gives ras_underflow=1 the next cycle with count staying 0; with RAS_CKPT_STATS_EN, overflow=1 and underflow=1.
3. Push 31'hA, then push+pop together with push_target=31'hB -> pop_target=31'hA in that cycle. Next cycle pop_target=31'hB with count=1 and index unchanged.
4. Push 31'h10 and 31'h20, then sample tag {index=2, count=2}. Pop, then push 31'h30. Then restore_valid with {2,2} -> index=2, count=2, pop_target=31'h30, confirming array contents are not restored.
5. Assert restore_valid, push_valid and pop_valid together -> only the restore applies, with no array write. restore_count=15 with RAS_ENTRIES=8 -> ras_count=8.
6. Assert RST during a push+pop cycle -> next cycle ptr=0, count=0, pop_target=0, ras_underflow=0, and stat counters are 0.

Source files
------------

// File: rtl/ras_ckpt.sv
// ras_ckpt -- parametrised return address stack with checkpoint restore.
//
// Circular stack of RAS_ENTRIES return targets for the fetch predictors.
// ptr points at the current top entry and count tracks valid entries,
// saturating at RAS_ENTRIES. A push onto a full stack silently overwrites
// the oldest entry. The {ras_index, ras_count} pair forms the checkpoint tag
// held by the checkpoint array and ROB. On a flush, that tag is driven back
// through the restore port. A push and a pop in the same cycle replace the
// top entry, which is the jalr call-return case.
//
// Ports:
//   CLK, RST        clock; synchronous active-high reset
//   push_valid      push request (call), with push_target
//   pop_valid       pop request (return)
//   pop_target      top-of-stack entry, combinational from array[ptr]
//   ras_index       top pointer (checkpoint tag)
//   ras_count       valid entry count 0..RAS_ENTRIES (checkpoint tag)
//   ras_empty       ras_count == 0
//   ras_underflow   registered, one cycle after a pop while empty
//   restore_valid   restore ptr/count from restore_index/restore_count
//
// Optional feature, macro RAS_CKPT_STATS_EN:
//   stat_overflow_count   pushes made while full (saturating, 16 bit)
//   stat_underflow_count  pop-only requests made while empty (saturating)
//   Both counters are cleared by RST and are not affected by restore.

module ras_ckpt #(
    parameter int RAS_ENTRIES      = 8,
    parameter int RAS_INDEX_WIDTH  = $clog2(RAS_ENTRIES),
    parameter int RAS_TARGET_WIDTH = 31
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        push_valid,
    input  logic [RAS_TARGET_WIDTH-1:0] push_target,
    input  logic                        pop_valid,
    output logic [RAS_TARGET_WIDTH-1:0] pop_target,
    output logic [RAS_INDEX_WIDTH-1:0]  ras_index,
    output logic [RAS_INDEX_WIDTH:0]    ras_count,
    output logic                        ras_empty,
    output logic                        ras_underflow,
    input  logic                        restore_valid,
    input  logic [RAS_INDEX_WIDTH-1:0]  restore_index,
    input  logic [RAS_INDEX_WIDTH:0]    restore_count
`ifdef RAS_CKPT_STATS_EN
    ,
    output logic [15:0]                 stat_overflow_count,
    output logic [15:0]                 stat_underflow_count
`endif
);

    localparam logic [RAS_INDEX_WIDTH:0] LP_FULL = (RAS_INDEX_WIDTH+1)'(RAS_ENTRIES);

    logic [RAS_TARGET_WIDTH-1:0] r_mem [RAS_ENTRIES];
    logic [RAS_INDEX_WIDTH-1:0]  r_ptr;
    logic [RAS_INDEX_WIDTH:0]    r_count;
    logic                        r_underflow;

    logic                        w_full;
    logic                        w_empty;
    logic [RAS_INDEX_WIDTH-1:0]  w_ptr_inc;
    logic [RAS_INDEX_WIDTH-1:0]  w_ptr_dec;
    logic [RAS_INDEX_WIDTH:0]    w_restore_cnt;

    assign w_full        = (r_count == LP_FULL);
    assign w_empty       = (r_count == '0);
    // Pointer width equals log2(depth), so natural wrap gives mod RAS_ENTRIES.
    assign w_ptr_inc     = r_ptr + 1'b1;
    assign w_ptr_dec     = r_ptr - 1'b1;
    assign w_restore_cnt = (restore_count > LP_FULL) ? LP_FULL : restore_count;

    assign pop_target    = r_mem[r_ptr];
    assign ras_index     = r_ptr;
    assign ras_count     = r_count;
    assign ras_empty     = w_empty;
    assign ras_underflow = r_underflow;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ptr       <= '0;
            r_count     <= '0;
            r_underflow <= 1'b0;
            for (int i = 0; i < RAS_ENTRIES; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_underflow <= 1'b0;
            if (restore_valid) begin
                // Array contents are left as they are; entries overwritten
                // after the checkpoint was taken stay overwritten.
                r_ptr   <= restore_index;
                r_count <= w_restore_cnt;
            end else if (push_valid && pop_valid) begin
                // Replace the top in place; an empty stack becomes one entry.
                r_mem[r_ptr] <= push_target;
                if (w_empty) begin
                    r_count <= (RAS_INDEX_WIDTH+1)'(1);
                end
            end else if (push_valid) begin
                r_ptr            <= w_ptr_inc;
                r_mem[w_ptr_inc] <= push_target;
                if (!w_full) begin
                    r_count <= r_count + 1'b1;
                end
            end else if (pop_valid) begin
                if (!w_empty) begin
                    r_ptr   <= w_ptr_dec;
                    r_count <= r_count - 1'b1;
                end else begin
                    r_underflow <= 1'b1;
                end
            end
        end
    end

`ifdef RAS_CKPT_STATS_EN
    logic [15:0] r_stat_ovf;
    logic [15:0] r_stat_unf;

    assign stat_overflow_count  = r_stat_ovf;
    assign stat_underflow_count = r_stat_unf;

    // Only a push-only that actually loses the oldest entry counts as an
    // overflow; a replace never drops an entry. Restore cycles ignore
    // push/pop, so they never count.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_stat_ovf <= '0;
            r_stat_unf <= '0;
        end else if (!restore_valid) begin
            if (push_valid && !pop_valid && w_full && (r_stat_ovf != 16'hFFFF)) begin
                r_stat_ovf <= r_stat_ovf + 16'd1;
            end
            if (pop_valid && !push_valid && w_empty && (r_stat_unf != 16'hFFFF)) begin
                r_stat_unf <= r_stat_unf + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ras_ckpt.sv
// Directed bench for ras_ckpt (RAS_ENTRIES=8). Inputs change 1 time unit
// after the rising edge. Outputs are sampled in the same window, so they
// reflect the state after that edge and, where relevant, the inputs of
// the current cycle.

module tb_ras_ckpt;

    localparam int N  = 8;
    localparam int IW = 3;
    localparam int TW = 31;

    logic          CLK = 1'b0;
    logic          RST;
    logic          push_valid;
    logic [TW-1:0] push_target;
    logic          pop_valid;
    logic [TW-1:0] pop_target;
    logic [IW-1:0] ras_index;
    logic [IW:0]   ras_count;
    logic          ras_empty;
    logic          ras_underflow;
    logic          restore_valid;
    logic [IW-1:0] restore_index;
    logic [IW:0]   restore_count;
`ifdef RAS_CKPT_STATS_EN
    logic [15:0]   stat_overflow_count;
    logic [15:0]   stat_underflow_count;
`endif

    int errors = 0;
    int checks = 0;

    ras_ckpt #(.RAS_ENTRIES(N), .RAS_TARGET_WIDTH(TW)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .push_valid    (push_valid),
        .push_target   (push_target),
        .pop_valid     (pop_valid),
        .pop_target    (pop_target),
        .ras_index     (ras_index),
        .ras_count     (ras_count),
        .ras_empty     (ras_empty),
        .ras_underflow (ras_underflow),
        .restore_valid (restore_valid),
        .restore_index (restore_index),
        .restore_count (restore_count)
`ifdef RAS_CKPT_STATS_EN
        ,
        .stat_overflow_count  (stat_overflow_count),
        .stat_underflow_count (stat_underflow_count)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        RST = 0; push_valid = 0; pop_valid = 0; restore_valid = 0;
        push_target = '0; restore_index = '0; restore_count = '0;
    endtask

    task automatic do_reset();
        idle();
        RST = 1;
        tick();
        RST = 0;
    endtask

    task automatic push(input logic [TW-1:0] t);
        push_valid = 1; push_target = t;
        tick();
        push_valid = 0;
    endtask

    task automatic pop();
        pop_valid = 1;
        tick();
        pop_valid = 0;
    endtask

    initial begin
        idle();
        do_reset();
        // Reset state
        chk("rst_top",   32'(pop_target),    32'h0);
        chk("rst_index", 32'(ras_index),     32'h0);
        chk("rst_count", 32'(ras_count),     32'h0);
        chk("rst_empty", 32'(ras_empty),     32'h1);
        chk("rst_unf",   32'(ras_underflow), 32'h0);

        // 1: basic LIFO
        push(31'h100); push(31'h200); push(31'h300);
        chk("t1_count", 32'(ras_count),  32'd3);
        chk("t1_index", 32'(ras_index),  32'd3);
        chk("t1_top",   32'(pop_target), 32'h300);
        pop();
        chk("t1_pop1", 32'(pop_target), 32'h200);
        pop();
        chk("t1_pop2", 32'(pop_target), 32'h100);
        chk("t1_cnt1", 32'(ras_count),  32'd1);
        pop();
        chk("t1_empty", 32'(ras_empty), 32'h1);
        chk("t1_cnt0",  32'(ras_count), 32'd0);

        // 2: saturation, wrap, underflow
        do_reset();
        for (int i = 1; i <= 9; i++) push(TW'(i));
        chk("t2_count", 32'(ras_count),  32'd8);
        chk("t2_index", 32'(ras_index),  32'd1);
        for (int i = 9; i >= 2; i--) begin
            chk($sformatf("t2_top%0d", i), 32'(pop_target), 32'(i));
            pop();
        end
        chk("t2_cnt0", 32'(ras_count),     32'd0);
        chk("t2_unf0", 32'(ras_underflow), 32'h0);
        pop();
        chk("t2_unf1",   32'(ras_underflow), 32'h1);
        chk("t2_cnt_uf", 32'(ras_count),     32'd0);
        chk("t2_idx_uf", 32'(ras_index),     32'd1);
        chk("t2_stale",  32'(pop_target),    32'h9);
`ifdef RAS_CKPT_STATS_EN
        chk("t2_ovf_stat", 32'(stat_overflow_count),  32'd1);
        chk("t2_unf_stat", 32'(stat_underflow_count), 32'd1);
`endif
        tick();
        chk("t2_unf_clr", 32'(ras_underflow), 32'h0);

        // 3: push+pop replaces the top
        do_reset();
        push(31'hA);
        push_valid = 1; pop_valid = 1; push_target = 31'hB;
        #1;
        chk("t3_old_top", 32'(pop_target), 32'hA);
        tick();
        push_valid = 0; pop_valid = 0;
        chk("t3_new_top", 32'(pop_target),    32'hB);
        chk("t3_count",   32'(ras_count),     32'd1);
        chk("t3_index",   32'(ras_index),     32'd1);
        chk("t3_no_unf",  32'(ras_underflow), 32'h0);

        // 3b: replace on an empty stack yields count 1, no underflow
        do_reset();
        push_valid = 1; pop_valid = 1; push_target = 31'hC;
        tick();
        push_valid = 0; pop_valid = 0;
        chk("t3b_count", 32'(ras_count),     32'd1);
        chk("t3b_top",   32'(pop_target),    32'hC);
        chk("t3b_unf",   32'(ras_underflow), 32'h0);

        // 4: checkpoint restore leaves the array untouched
        do_reset();
        push(31'h10); push(31'h20);
        chk("t4_tag_idx", 32'(ras_index), 32'd2);
        chk("t4_tag_cnt", 32'(ras_count), 32'd2);
        pop();
        push(31'h30);
        restore_valid = 1; restore_index = 3'd2; restore_count = 4'd2;
        tick();
        restore_valid = 0;
        chk("t4_idx", 32'(ras_index),  32'd2);
        chk("t4_cnt", 32'(ras_count),  32'd2);
        chk("t4_top", 32'(pop_target), 32'h30);
        restore_valid = 1; restore_index = 3'd1; restore_count = 4'd1;
        tick();
        restore_valid = 0;
        chk("t4_r1_top", 32'(pop_target), 32'h10);
        chk("t4_r1_cnt", 32'(ras_count),  32'd1);

        // 5: restore wins over push+pop; count clamps
        restore_valid = 1; restore_index = 3'd5; restore_count = 4'd15;
        push_valid = 1; pop_valid = 1; push_target = 31'h77;
        tick();
        idle();
        chk("t5_idx",   32'(ras_index),  32'd5);
        chk("t5_cnt",   32'(ras_count),  32'd8);
        chk("t5_top",   32'(pop_target), 32'h0);
        restore_valid = 1; restore_index = 3'd1; restore_count = 4'd1;
        tick();
        restore_valid = 0;
        chk("t5_nowr", 32'(pop_target), 32'h10);
        // Exactly RAS_ENTRIES is not clamped further
        restore_valid = 1; restore_index = 3'd2; restore_count = 4'd8;
        tick();
        restore_valid = 0;
        chk("t5_cnt8", 32'(ras_count),  32'd8);
        chk("t5_top2", 32'(pop_target), 32'h30);

        // 6: reset during push+pop, right after an empty-pop
        do_reset();
        push(31'h55);
        pop();
        pop();
        chk("t6_unf_pre", 32'(ras_underflow), 32'h1);
        RST = 1; push_valid = 1; pop_valid = 1; push_target = 31'h66;
        tick();
        idle();
        chk("t6_idx", 32'(ras_index),     32'd0);
        chk("t6_cnt", 32'(ras_count),     32'd0);
        chk("t6_top", 32'(pop_target),    32'h0);
        chk("t6_unf", 32'(ras_underflow), 32'h0);
        chk("t6_emp", 32'(ras_empty),     32'h1);
`ifdef RAS_CKPT_STATS_EN
        chk("t6_ovf_stat", 32'(stat_overflow_count),  32'd0);
        chk("t6_unf_stat", 32'(stat_underflow_count), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
